// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler in front of one shared signed multiplier.
// Grants at most one operation per cycle and returns each product with a one-hot done pulse.
module mul_rr_scheduler #(
    parameter int width     = 16,
    parameter int n_clients = 2,
    parameter int latency   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [n_clients-1:0]   req,
    input  logic [width-1:0]       x [n_clients],
    input  logic [width-1:0]       y [n_clients],
    output logic [2*width-1:0]     prod,
    output logic [n_clients-1:0]   done,
    output logic [n_clients-1:0]   grant,
    output logic                   idle
);

    localparam int idx_w = (n_clients > 1) ? $clog2(n_clients) : 1;

    logic [idx_w-1:0]     last_grant_r;
    logic [idx_w-1:0]     cand_s;
    logic [idx_w-1:0]     win_idx_s;
    logic                 win_found_s;
    logic [n_clients-1:0] eligible_s;
    logic [n_clients-1:0] grant_s;
    logic [n_clients-1:0] in_flight_r;
    logic [n_clients-1:0] in_flight_s;
    logic [n_clients-1:0] grant_r;
    logic [n_clients-1:0] done_r;
    logic [n_clients-1:0] done_s;
    logic                 idle_r;

    logic                 stage_valid_r [latency];
    logic [idx_w-1:0]     stage_idx_r   [latency];
    logic [width-1:0]     stage_x_r     [latency];
    logic [width-1:0]     stage_y_r     [latency];

    logic [2*width-1:0]   mult_s;
    logic [2*width-1:0]   prod_r;

    // Round-robin pick: first eligible client after the last one granted.
    always_comb begin
        eligible_s  = req & ~in_flight_r;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        grant_s     = '0;
        for (int k = 0; k < n_clients; k++) begin
            cand_s = idx_w'((int'(last_grant_r) + 1 + k) % n_clients);
            if (!win_found_s && eligible_s[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
        for (int i = 0; i < n_clients; i++) begin
            grant_s[i] = win_found_s && (win_idx_s == idx_w'(i));
        end
        // A done bit releases its client on the edge that ends the pulse.
        in_flight_s = (in_flight_r & ~done_r) | grant_s;
    end

    // Full-precision signed product and completion decode at the last stage.
    always_comb begin
        mult_s = {{width{stage_x_r[latency-1][width-1]}}, stage_x_r[latency-1]} *
                 {{width{stage_y_r[latency-1][width-1]}}, stage_y_r[latency-1]};
        done_s = '0;
        for (int i = 0; i < n_clients; i++) begin
            done_s[i] = stage_valid_r[latency-1] && (stage_idx_r[latency-1] == idx_w'(i));
        end
    end

    // Arbitration state, in-flight tracking, grant and idle outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= idx_w'(n_clients - 1);
            in_flight_r  <= '0;
            grant_r      <= '0;
            idle_r       <= 1'b1;
        end else begin
            in_flight_r <= in_flight_s;
            grant_r     <= grant_s;
            idle_r      <= (in_flight_s == '0) && (req == '0);
            if (win_found_s) begin
                last_grant_r <= win_idx_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Operand shift pipeline; stage 0 captures the winner's operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < latency; k++) begin
                stage_valid_r[k] <= 1'b0;
                stage_idx_r[k]   <= '0;
                stage_x_r[k]     <= '0;
                stage_y_r[k]     <= '0;
            end
        end else begin
            stage_valid_r[0] <= win_found_s;
            stage_idx_r[0]   <= win_idx_s;
            stage_x_r[0]     <= x[win_idx_s];
            stage_y_r[0]     <= y[win_idx_s];
            for (int k = 1; k < latency; k++) begin
                stage_valid_r[k] <= stage_valid_r[k-1];
                stage_idx_r[k]   <= stage_idx_r[k-1];
                stage_x_r[k]     <= stage_x_r[k-1];
                stage_y_r[k]     <= stage_y_r[k-1];
            end
        end
    end

    // Result register: prod holds its last value between completions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_r <= '0;
            prod_r <= '0;
        end else begin
            done_r <= done_s;
            if (stage_valid_r[latency-1]) begin
                prod_r <= mult_s;
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    assign prod  = prod_r;
    assign done  = done_r;
    assign grant = grant_r;
    assign idle  = idle_r;

endmodule
